// File: rtl/cnn_mac_pkg.sv
// rtl/cnn_mac_pkg.sv - shared widths, pipeline depth limits and saturation helpers for the MAC pipe
package cnn_mac_pkg;

  localparam int DEF_A_W        = 14;
  localparam int DEF_B_W        = 8;
  localparam int DEF_NUM_STAGE  = 2;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_FRAC_SHIFT = 6;
  localparam int DEF_OUT_W      = 14;

  localparam int NUM_STAGE_MIN  = 1;
  localparam int NUM_STAGE_MAX  = 4;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic int clamp_stages(input int n);
    if (n < NUM_STAGE_MIN) return NUM_STAGE_MIN;
    if (n > NUM_STAGE_MAX) return NUM_STAGE_MAX;
    return n;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// rtl/cnn_mac_mul_pipe.sv - signed multiplier with NUM_STAGE output registers carrying last and valid
module cnn_mac_mul_pipe #(
  parameter int A_W       = 14,
  parameter int B_W       = 8,
  parameter int NUM_STAGE = 2,
  localparam int P_W      = A_W + B_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic signed [P_W-1:0] o_prod,
  output logic                  o_last,
  output logic                  o_valid
);

  logic signed [P_W-1:0] r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]  r_last;
  logic [NUM_STAGE-1:0]  r_valid;

  // Product registers carry no reset so the tools can fold them into DSP pipeline registers.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_prod[0] <= P_W'(i_a) * P_W'(i_b);
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_prod[s] <= r_prod[s-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last  <= '0;
      r_valid <= '0;
    end else if (i_en) begin
      r_last[0]  <= i_last & i_valid;
      r_valid[0] <= i_valid;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_last[s]  <= r_last[s-1];
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  assign o_prod  = r_prod[NUM_STAGE-1];
  assign o_last  = r_last[NUM_STAGE-1];
  assign o_valid = r_valid[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// rtl/cnn_mac_pipe.sv - streaming signed dot-product MAC with rounding, saturation and backpressure
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int NUM_STAGE  = DEF_NUM_STAGE,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int P_W    = A_W + B_W;
  localparam int STAGES = clamp_stages(NUM_STAGE);

  // Half an output LSB; collapses to zero when no fractional bits are dropped.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((64'sd1 <<< FRAC_SHIFT) >>> 1);

  localparam longint SAT_HI = sat_max(OUT_W);
  localparam longint SAT_LO = sat_min(OUT_W);
  localparam logic signed [OUT_W-1:0] SAT_HI_O = OUT_W'(SAT_HI);
  localparam logic signed [OUT_W-1:0] SAT_LO_O = OUT_W'(SAT_LO);

  logic                    w_stall;
  logic                    w_en;
  logic signed [P_W-1:0]   w_prod;
  logic                    w_prod_last;
  logic                    w_prod_valid;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shifted;
  logic signed [63:0]      w_wide;
  logic                    w_hi;
  logic                    w_lo;
  logic signed [OUT_W-1:0] w_res;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_res_sum;
  logic                    r_res_valid;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  cnn_mac_mul_pipe #(
    .A_W       (A_W),
    .B_W       (B_W),
    .NUM_STAGE (STAGES)
  ) u_mul (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_en    (w_en),
    .i_valid (in_valid),
    .i_last  (in_last),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_prod  (w_prod),
    .o_last  (w_prod_last),
    .o_valid (w_prod_valid)
  );

  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

  // Closing beat hands its sum to the result stage and restarts the accumulator in the same cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc       <= '0;
      r_res_sum   <= '0;
      r_res_valid <= 1'b0;
    end else if (w_en) begin
      r_res_valid <= w_prod_valid & w_prod_last;
      if (w_prod_valid) begin
        if (w_prod_last) begin
          r_res_sum <= w_sum;
          r_acc     <= '0;
        end else begin
          r_acc     <= w_sum;
        end
      end
    end
  end

  // One guard bit keeps the rounding add from wrapping near the accumulator limits.
  assign w_rnd     = (ACC_W+1)'(r_res_sum) + RND;
  assign w_shifted = w_rnd >>> FRAC_SHIFT;
  assign w_wide    = 64'(w_shifted);
  assign w_hi      = w_wide > SAT_HI;
  assign w_lo      = w_wide < SAT_LO;
  assign w_res     = w_hi ? SAT_HI_O : (w_lo ? SAT_LO_O : w_shifted[OUT_W-1:0]);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_res_valid;
      if (r_res_valid) begin
        r_out_data <= w_res;
        r_out_sat  <= w_hi | w_lo;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb/tb_cnn_mac_pipe.sv - scoreboard bench for cnn_mac_pipe against an arithmetic dot-product model
module tb_cnn_mac_pipe;

  localparam int A_W        = 14;
  localparam int B_W        = 8;
  localparam int NUM_STAGE  = 2;
  localparam int ACC_W      = 32;
  localparam int FRAC_SHIFT = 6;
  localparam int OUT_W      = 14;

  logic                    ap_clk    = 1'b0;
  logic                    ap_rst_n  = 1'b1;
  logic                    in_valid  = 1'b0;
  logic                    in_ready;
  logic signed [A_W-1:0]   in_a      = '0;
  logic signed [B_W-1:0]   in_b      = '0;
  logic                    in_last   = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  cnn_mac_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .NUM_STAGE  (NUM_STAGE),
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_W      (OUT_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint data;
    bit     sat;
    int     cyc;
    bit     lat;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_checks   = 0;
  int     n_fail     = 0;
  int     cyc        = 0;
  int     ready_mode = 0;
  int     n_out      = 0;
  int     n_out_mark = 0;
  int     guard      = 0;
  longint model_acc  = 0;
  longint last_data  = 0;
  bit     last_sat   = 0;
  bit     prev_stall = 0;
  logic signed [OUT_W-1:0] prev_data;
  logic                    prev_sat;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Reference: wrap the exact sum to ACC_W bits, round half up, floor-shift, clip to OUT_W.
  function automatic exp_t reference(input longint acc);
    longint s;
    longint r;
    longint hi;
    longint lo;
    exp_t   e;
    s = acc & ((64'sd1 <<< ACC_W) - 1);
    if (s >= (64'sd1 <<< (ACC_W - 1))) s = s - (64'sd1 <<< ACC_W);
    r  = (s + ((64'sd1 <<< FRAC_SHIFT) / 2)) >>> FRAC_SHIFT;
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    e.sat  = (r > hi) || (r < lo);
    e.data = (r > hi) ? hi : ((r < lo) ? lo : r);
    e.cyc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      model_acc  = 0;
      prev_stall = 0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_sat", out_sat, prev_sat);
      end
      if (in_valid && in_ready) begin
        model_acc += longint'(in_a) * longint'(in_b);
        if (in_last) begin
          mon_e     = reference(model_acc);
          mon_e.cyc = cyc;
          mon_e.lat = (ready_mode == 0);
          exp_q.push_back(mon_e);
          model_acc = 0;
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_data = out_data;
        last_sat  = out_sat;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_sat", out_sat, mon_e.sat);
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, NUM_STAGE + 2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end
  end

  always @(posedge ap_clk) begin
    #1;
    if (ready_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send_beat(input int a, input int b, input bit last);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_a     = A_W'(a);
    in_b     = B_W'(b);
    in_last  = last;
    @(negedge ap_clk);
    while (!in_ready && g < 200) begin
      @(negedge ap_clk);
      g++;
    end
    if (g >= 200) fail_now("in_ready_timeout");
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 400) begin
      @(posedge ap_clk);
      #1;
      g++;
    end
    if (g >= 400) fail_now("drain_timeout");
    idle(2);
  endtask

  initial begin
    #1 ap_rst_n = 1'b0;
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    ap_rst_n = 1'b1;

    send_beat(100, 3, 0);
    send_beat(100, 3, 0);
    send_beat(100, 3, 1);
    drain();
    check("basic_data", last_data, 14);
    check("basic_sat", last_sat, 0);

    repeat (3) send_beat(8191, 127, 0);
    send_beat(8191, 127, 1);
    drain();
    check("sat_hi_data", last_data, 8191);
    check("sat_hi_flag", last_sat, 1);
    repeat (3) send_beat(-8192, 127, 0);
    send_beat(-8192, 127, 1);
    drain();
    check("sat_lo_data", last_data, -8192);
    check("sat_lo_flag", last_sat, 1);

    n_out_mark = n_out;
    send_beat(-1, 1, 1);
    send_beat(64, 1, 1);
    drain();
    check("single_count", n_out - n_out_mark, 2);
    check("single_last", last_data, 1);

    ready_mode = 2;
    out_ready  = 1'b0;
    n_out_mark = n_out;
    guard      = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_beat(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 255)) - 128, 1);
      end
      begin
        while (!out_valid && guard < 50) begin
          @(posedge ap_clk);
          #1;
          guard++;
        end
        if (guard >= 50) fail_now("stall_result_timeout");
        repeat (5) begin
          @(posedge ap_clk);
          #1;
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", n_out - n_out_mark, 6);
    ready_mode = 0;

    send_beat(10, 10, 0);
    send_beat(10, 10, 0);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge ap_clk);
    #1;
    ap_rst_n   = 1'b1;
    n_out_mark = n_out;
    send_beat(10, 10, 0);
    send_beat(10, 10, 1);
    drain();
    check("midrst_count", n_out - n_out_mark, 1);
    check("midrst_data", last_data, 3);

    ready_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send_beat(int'($urandom_range(0, 16383)) - 8192,
                     int'($urandom_range(0, 255)) - 128,
                     ($urandom_range(0, 3) == 0));
    end
    send_beat(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 255)) - 128, 1);
    drain();
    ready_mode = 0;
    out_ready  = 1'b1;
    idle(2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    fail_now("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
